// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//
// Sequencer for one loadable up-counter (load/pre/ret/a in, y/tc out).
// A command carries a start value, a repetition count and a preset select.
// For each command the counter is loaded with the start value, or preset to
// all ones. The controller then counts terminal-count events and reloads the
// counter after each one. It pulses done when the last repetition ends.
// This block is the only driver of the counter's control inputs.
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   ret        in   1      synchronous active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      command can be accepted (IDLE only)
//   cmd_start  in   CNT_W  counter start value
//   cmd_reps   in   REP_W  number of tc events to run (0 = no-op)
//   cmd_pre    in   1      1: preset counter to all ones instead of loading
//   abort      in   1      abandon the running command
//   cnt_tc     in   1      terminal count from the counter
//   cnt_a      out  CNT_W  load value to the counter
//   cnt_load   out  1      counter load strobe
//   cnt_pre    out  1      counter preset strobe
//   cnt_ret    out  1      counter reset (holds counter at 0)
//   busy       out  1      command in progress (LOAD or RUN)
//   rep_cnt    out  REP_W  tc events counted for the current command
//   done       out  1      one-cycle pulse, command completed
//   aborted    out  1      one-cycle pulse, command abandoned
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int CNT_W = 4,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             ret,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_start,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             cmd_pre,
    input  logic             abort,
    input  logic             cnt_tc,
    output logic [CNT_W-1:0] cnt_a,
    output logic             cnt_load,
    output logic             cnt_pre,
    output logic             cnt_ret,
    output logic             busy,
    output logic [REP_W-1:0] rep_cnt,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   start_q, start_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic               pre_q, pre_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic [REP_W-1:0]   rep_inc;
    logic               last_rep;
    logic               reload;

    assign rep_inc  = rep_cnt_q + REP_W'(1);
    assign last_rep = (rep_inc == reps_q);

    // A single reload request is steered to exactly one of the two strobes,
    // so load and preset can never be asserted together.
    assign cnt_load = reload & ~pre_q;
    assign cnt_pre  = reload &  pre_q;

    assign rep_cnt  = rep_cnt_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        reps_d    = reps_q;
        pre_d     = pre_q;
        rep_cnt_d = rep_cnt_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        cmd_ready = 1'b0;
        cnt_ret   = 1'b0;
        busy      = 1'b0;
        reload    = 1'b0;
        cnt_a     = '0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                cnt_ret   = 1'b1;
                if (cmd_valid) begin
                    start_d   = cmd_start;
                    reps_d    = cmd_reps;
                    pre_d     = cmd_pre;
                    rep_cnt_d = '0;
                    if (cmd_reps == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                busy   = 1'b1;
                cnt_a  = start_q;
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    reload  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy  = 1'b1;
                cnt_a = start_q;
                // abort wins over a coincident tc, including the final one,
                // and leaves rep_cnt at its pre-abort value.
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_tc) begin
                    rep_cnt_d = rep_inc;
                    if (last_rep) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Reload in the tc cycle so the next period starts
                        // from the start value without a gap.
                        reload = 1'b1;
                    end
                end
            end

            S_DONE: begin
                cnt_ret = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (ret) begin
            state_q   <= S_IDLE;
            start_q   <= '0;
            reps_q    <= '0;
            pre_q     <= 1'b0;
            rep_cnt_q <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            reps_q    <= reps_d;
            pre_q     <= pre_d;
            rep_cnt_q <= rep_cnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

endmodule
